// File: rtl/branch_predict_cmp_pkg.sv
// Shared definitions for the branch evaluator / bimodal predictor slice:
// opcode and REGIMM rt encodings, 2-bit counter states and the saturating update.
package branch_predict_cmp_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;

   localparam logic [4:0] RT_BLTZ    = 5'b00000;
   localparam logic [4:0] RT_BGEZ    = 5'b00001;
   localparam logic [4:0] RT_BLTZAL  = 5'b10000;
   localparam logic [4:0] RT_BGEZAL  = 5'b10001;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Move one step toward the observed outcome, pinned at SNT and ST.
   function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
      if (taken)
         return (cnt == ST) ? ST : cnt + 2'd1;
      else
         return (cnt == SNT) ? SNT : cnt - 2'd1;
   endfunction

endpackage

// File: rtl/branch_predict_cmp_if.sv
// Pipeline-facing bundle of the predictor: IF lookup, ID resolve and event counters.
interface branch_predict_cmp_if #(
   parameter int DATA_W = 32,
   parameter int STAT_W = 32
);
   // No back-pressure: an ID-stage branch is consumed (trains the BHT and counts)
   // on any rising edge where id_valid is high and stall is low; stall only freezes state.
   logic              stall;
   logic [31:0]       if_pc;
   logic              if_pred_taken;
   logic              id_valid;
   logic [31:0]       id_pc;
   logic [5:0]        id_op;
   logic [4:0]        id_rt;
   logic [DATA_W-1:0] id_a;
   logic [DATA_W-1:0] id_b;
   logic              id_pred_taken;
   logic              id_is_branch;
   logic              id_taken;
   logic              id_link;
   logic              id_mispredict;
   logic [STAT_W-1:0] stat_branches;
   logic [STAT_W-1:0] stat_mispred;

   modport master (
      output stall, if_pc, id_valid, id_pc, id_op, id_rt, id_a, id_b, id_pred_taken,
      input  if_pred_taken, id_is_branch, id_taken, id_link, id_mispredict,
             stat_branches, stat_mispred
   );

   modport slave (
      input  stall, if_pc, id_valid, id_pc, id_op, id_rt, id_a, id_b, id_pred_taken,
      output if_pred_taken, id_is_branch, id_taken, id_link, id_mispredict,
             stat_branches, stat_mispred
   );
endinterface

// File: rtl/branch_predict_cmp_branch_cond.sv
// Combinational branch decode and condition evaluation for the
// BEQ/BNE/BLEZ/BGTZ and REGIMM (BLTZ/BGEZ/BLTZAL/BGEZAL) families.
module branch_cond
   import branch_predict_cmp_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [5:0]        op,
   input  logic [4:0]        rt,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              is_branch,
   output logic              taken,
   output logic              link
);

   logic a_neg;
   logic a_zero;

   assign a_neg  = a[DATA_W-1];
   assign a_zero = (a == '0);

   always_comb begin
      is_branch = 1'b0;
      taken     = 1'b0;
      link      = 1'b0;
      case (op)
         OP_BEQ: begin
            is_branch = 1'b1;
            taken     = (a == b);
         end
         OP_BNE: begin
            is_branch = 1'b1;
            taken     = (a != b);
         end
         OP_BLEZ: begin
            is_branch = 1'b1;
            taken     = a_neg | a_zero;
         end
         OP_BGTZ: begin
            is_branch = 1'b1;
            taken     = ~a_neg & ~a_zero;
         end
         OP_REGIMM: begin
            // Unsupported rt values leave everything at zero.
            case (rt)
               RT_BLTZ, RT_BLTZAL: begin
                  is_branch = 1'b1;
                  taken     = a_neg;
                  link      = (rt == RT_BLTZAL);
               end
               RT_BGEZ, RT_BGEZAL: begin
                  is_branch = 1'b1;
                  taken     = ~a_neg;
                  link      = (rt == RT_BGEZAL);
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/branch_predict_cmp.sv
// Branch condition evaluator with a bimodal BHT of 2-bit saturating counters,
// zero-latency IF prediction / ID mispredict flag, and saturating event counters.
module branch_predict_cmp
   import branch_predict_cmp_pkg::*;
#(
   parameter int         DATA_W      = 32,
   parameter int         BHT_ENTRIES = 64,
   parameter logic [1:0] CNT_INIT    = WNT,
   parameter int         STAT_W      = 32
) (
   input logic                 clk,
   input logic                 rst,
   branch_predict_cmp_if.slave bus
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]        bht [BHT_ENTRIES];
   logic [IDX_W-1:0]  if_idx;
   logic [IDX_W-1:0]  id_idx;
   logic              is_branch;
   logic              taken;
   logic              link;
   logic              train;
   logic              mispredict;
   logic [STAT_W-1:0] stat_branches;
   logic [STAT_W-1:0] stat_mispred;
   logic              unused_pc_bits;

   assign if_idx = bus.if_pc[IDX_W+1:2];
   assign id_idx = bus.id_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0],
                             bus.id_pc[31:IDX_W+2], bus.id_pc[1:0]};

   branch_cond #(.DATA_W(DATA_W)) u_cond (
      .op        (bus.id_op),
      .rt        (bus.id_rt),
      .a         (bus.id_a),
      .b         (bus.id_b),
      .is_branch (is_branch),
      .taken     (taken),
      .link      (link)
   );

   assign mispredict = bus.id_valid & is_branch & (taken != bus.id_pred_taken);
   assign train      = bus.id_valid & is_branch & ~bus.stall;

   // Plain array read: a same-cycle write to this index shows up one cycle later.
   assign bus.if_pred_taken = bht[if_idx][1];
   assign bus.id_is_branch  = is_branch;
   assign bus.id_taken      = taken;
   assign bus.id_link       = link;
   assign bus.id_mispredict = mispredict;
   assign bus.stat_branches = stat_branches;
   assign bus.stat_mispred  = stat_mispred;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++)
            bht[i] <= CNT_INIT;
      end else if (train) begin
         bht[id_idx] <= cnt_update(bht[id_idx], taken);
      end
   end

   // Event counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else if (train) begin
         if (stat_branches != '1)
            stat_branches <= stat_branches + STAT_W'(1);
         if (mispredict && (stat_mispred != '1))
            stat_mispred <= stat_mispred + STAT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_predict_cmp.sv
// Directed and randomized checks of branch_predict_cmp against a behavioural
// model of the branch rules, the bimodal counters and the event counters.
module tb_branch_predict_cmp;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   int    m_bht [64];
   longint m_branches;
   longint m_mispred;

   localparam longint STAT_MAX = 64'hFFFF_FFFF;

   branch_predict_cmp_if #(.DATA_W(32), .STAT_W(32)) bus ();

   branch_predict_cmp #(
      .DATA_W(32), .BHT_ENTRIES(64), .CNT_INIT(2'b01), .STAT_W(32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int bidx(input logic [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   function automatic void model_cond(input logic [5:0] op, input logic [4:0] rt,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output bit br, output bit tk, output bit lk);
      br = 0; tk = 0; lk = 0;
      case (op)
         6'd4: begin br = 1; tk = (a == b); end
         6'd5: begin br = 1; tk = (a != b); end
         6'd6: begin br = 1; tk = ($signed(a) <= 0); end
         6'd7: begin br = 1; tk = ($signed(a) > 0); end
         6'd1: begin
            if (rt == 5'd0 || rt == 5'd16) begin
               br = 1; tk = ($signed(a) < 0); lk = (rt == 5'd16);
            end else if (rt == 5'd1 || rt == 5'd17) begin
               br = 1; tk = ($signed(a) >= 0); lk = (rt == 5'd17);
            end
         end
         default: ;
      endcase
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      m_branches = 0;
      m_mispred  = 0;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive_id(input logic valid, input logic [31:0] pc, input logic [5:0] op,
                           input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b,
                           input logic pred);
      bus.id_valid      = valid;
      bus.id_pc         = pc;
      bus.id_op         = op;
      bus.id_rt         = rt;
      bus.id_a          = a;
      bus.id_b          = b;
      bus.id_pred_taken = pred;
   endtask

   // Compare all combinational ID outputs plus the IF prediction against the model.
   task automatic check_comb(input string tag);
      bit br, tk, lk, mp;
      model_cond(bus.id_op, bus.id_rt, bus.id_a, bus.id_b, br, tk, lk);
      mp = bus.id_valid && br && (tk != bus.id_pred_taken);
      check({tag, ".is_branch"}, 64'(bus.id_is_branch), 64'(br));
      check({tag, ".taken"}, 64'(bus.id_taken), 64'(tk));
      check({tag, ".link"}, 64'(bus.id_link), 64'(lk));
      check({tag, ".mispredict"}, 64'(bus.id_mispredict), 64'(mp));
      check({tag, ".if_pred"}, 64'(bus.if_pred_taken), 64'(m_bht[bidx(bus.if_pc)] >= 2));
   endtask

   // Apply the model's view of the coming edge, then advance past it.
   task automatic tick();
      bit br, tk, lk;
      int k;
      model_cond(bus.id_op, bus.id_rt, bus.id_a, bus.id_b, br, tk, lk);
      if (!rst && bus.id_valid && br && !bus.stall) begin
         k = bidx(bus.id_pc);
         m_bht[k] = tk ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3) : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
         if (m_branches < STAT_MAX) m_branches++;
         if (tk != bus.id_pred_taken && m_mispred < STAT_MAX) m_mispred++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_stats(input string tag);
      check({tag, ".stat_branches"}, 64'(bus.stat_branches), 64'(m_branches));
      check({tag, ".stat_mispred"}, 64'(bus.stat_mispred), 64'(m_mispred));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] p5, q6, r7;
      logic [5:0]  ops [8];
      logic [4:0]  rts [6];
      logic [31:0] a, b, pc;
      n_tests = 0;
      n_fail  = 0;
      ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd0, 6'd2, 6'd35};

      rst = 1'b1;
      bus.stall = 1'b0;
      bus.if_pc = 32'h0040_0010;
      drive_id(1'b0, 32'h0, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset.if_pred", 64'(bus.if_pred_taken), 64'd0);
      check_stats("reset");
      @(negedge clk);
      rst = 1'b0;
      #1;

      // 1. after reset
      check("t1.if_pred", 64'(bus.if_pred_taken), 64'd0);
      check_stats("t1");

      // 2. BEQ equal, predicted not-taken
      drive_id(1'b1, 32'h0040_0010, 6'd4, 5'd0, 32'h1234, 32'h1234, 1'b0);
      #1;
      check("t2.taken", 64'(bus.id_taken), 64'd1);
      check("t2.mispredict", 64'(bus.id_mispredict), 64'd1);
      tick();
      bus.id_valid = 1'b0;
      #1;
      check("t2.if_pred_after", 64'(bus.if_pred_taken), 64'd1);
      check_stats("t2");

      // 3. BGTZ / BLEZ boundary operands, no training
      a = 32'h8000_0000;
      drive_id(1'b0, 32'h0040_0020, 6'd7, 5'd0, a, 32'h0, 1'b0); #1;
      check("t3.bgtz_neg", 64'(bus.id_taken), 64'd0);
      bus.id_a = 32'h0; #1;
      check("t3.bgtz_zero", 64'(bus.id_taken), 64'd0);
      bus.id_a = 32'h1; #1;
      check("t3.bgtz_one", 64'(bus.id_taken), 64'd1);
      drive_id(1'b0, 32'h0040_0020, 6'd6, 5'd0, a, 32'h0, 1'b0); #1;
      check("t3.blez_neg", 64'(bus.id_taken), 64'd1);
      bus.id_a = 32'h0; #1;
      check("t3.blez_zero", 64'(bus.id_taken), 64'd1);
      bus.id_a = 32'h1; #1;
      check("t3.blez_one", 64'(bus.id_taken), 64'd0);
      check("t3.mispredict_invalid", 64'(bus.id_mispredict), 64'd0);
      tick();
      check_stats("t3");

      // 4. REGIMM BGEZAL and an unsupported rt
      drive_id(1'b1, 32'h0040_0030, 6'd1, 5'b10001, 32'd5, 32'd0, 1'b1); #1;
      check("t4.bgezal_taken", 64'(bus.id_taken), 64'd1);
      check("t4.bgezal_link", 64'(bus.id_link), 64'd1);
      tick();
      check_stats("t4.bgezal");
      drive_id(1'b1, 32'h0040_0040, 6'd1, 5'b00010, 32'hFFFF_FFFF, 32'd0, 1'b1); #1;
      check("t4.bad_rt_branch", 64'(bus.id_is_branch), 64'd0);
      check("t4.bad_rt_taken", 64'(bus.id_taken), 64'd0);
      tick();
      check_stats("t4.bad_rt");
      bus.if_pc = 32'h0040_0040; #1;
      check("t4.bad_rt_bht", 64'(bus.if_pred_taken), 64'd0);

      // 5. saturation, decrement, stall hold
      p5 = 32'h0040_0100;
      bus.if_pc = p5;
      for (int i = 0; i < 4; i++) begin
         drive_id(1'b1, p5, 6'd5, 5'd0, 32'd1, 32'd2, bus.if_pred_taken); #1;
         check_comb("t5.bne");
         tick();
      end
      check("t5.sat_pred", 64'(bus.if_pred_taken), 64'd1);
      drive_id(1'b1, p5, 6'd5, 5'd0, 32'd7, 32'd7, 1'b1); #1;
      tick();
      check("t5.after_nt", 64'(bus.if_pred_taken), 64'd1);
      bus.stall = 1'b1; #1;
      check("t5.stall_mispredict", 64'(bus.id_mispredict), 64'd1);
      tick();
      check("t5.stall_hold", 64'(bus.if_pred_taken), 64'd1);
      check_stats("t5.stall");
      bus.stall = 1'b0;
      tick();
      check("t5.second_nt", 64'(bus.if_pred_taken), 64'd0);
      check_stats("t5");

      // 6. IF/ID index collision: old value visible this cycle, new value next
      q6 = 32'h0040_0200;
      bus.if_pc = q6;
      drive_id(1'b1, q6, 6'd4, 5'd0, 32'd9, 32'd9, 1'b0); #1;
      check("t6.collide_now", 64'(bus.if_pred_taken), 64'd0);
      tick();
      bus.id_valid = 1'b0; #1;
      check("t6.collide_next", 64'(bus.if_pred_taken), 64'd1);

      // Randomized traffic with aliasing PCs
      rts = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd2, 5'd31};
      for (int n = 0; n < 400; n++) begin
         pc = 32'h0040_0000 + ($urandom_range(0, 15) << 2) + ($urandom_range(0, 1) << 8);
         a  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
         drive_id($urandom_range(0, 9) != 0, pc, ops[$urandom_range(0, 7)],
                  rts[$urandom_range(0, 5)], a, b, 1'($urandom_range(0, 1)));
         bus.stall = ($urandom_range(0, 6) == 0);
         bus.if_pc = ($urandom_range(0, 3) == 0) ? pc :
                     32'h0040_0000 + ($urandom_range(0, 15) << 2) + ($urandom_range(0, 1) << 8);
         #1;
         check_comb("rnd");
         tick();
         check_stats("rnd");
      end

      // Asynchronous reset mid-stream
      bus.stall = 1'b0;
      r7 = 32'h0040_0300;
      bus.if_pc = r7;
      for (int i = 0; i < 3; i++) begin
         drive_id(1'b1, r7, 6'd4, 5'd0, 32'd3, 32'd3, 1'b1); #1;
         tick();
      end
      check("rst.pre_pred", 64'(bus.if_pred_taken), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      check("rst.async_pred", 64'(bus.if_pred_taken), 64'd0);
      check_stats("rst.async");
      tick();
      check("rst.edge_lost", 64'(bus.if_pred_taken), 64'd0);
      check_stats("rst.edge_lost");
      @(negedge clk);
      rst = 1'b0;
      #1;
      tick();
      check("rst.after_train", 64'(bus.if_pred_taken), 64'd1);
      check_stats("rst.after");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
